// File: rtl/eth_recv.sv
// Test-frame receiver/monitor on a 64-bit MAC RX stream: counters update 1 cycle after tlast, no backpressure (no tready).
// Optional sequence checking (seq latch, rx_seq_err_cnt, rx_last_seq) is enabled by defining ETH_RECV_SEQ_CHECK_EN.
module eth_recv #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst_n,
  input  logic                 s_axis_tvalid,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [CNT_WIDTH-1:0] rx_frame_cnt,
  output logic [47:0]          rx_byte_cnt,
  output logic [CNT_WIDTH-1:0] rx_bad_cnt,
  output logic [CNT_WIDTH-1:0] rx_runt_cnt,
  output logic [CNT_WIDTH-1:0] rx_seq_err_cnt,
  output logic [31:0]          rx_last_seq,
  output logic                 rx_frame_pulse
);

  typedef enum logic [2:0] {S_SYNC, S_B0, S_B1, S_B2, S_BODY} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t      state;
  logic [15:0] etype;
  logic [15:0] len_acc;
  logic [3:0]  keep_ones;
  logic [15:0] frame_len;
  logic [48:0] byte_sum;
  logic        is_runt;
  logic        unused_bits;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    keep_ones = 4'd0;
    for (int i = 0; i < 8; i++) keep_ones = keep_ones + {3'b000, s_axis_tkeep[i]};
    frame_len = len_acc + {12'd0, keep_ones};
    byte_sum  = {1'b0, rx_byte_cnt} + {33'd0, frame_len};
    is_runt   = (state == S_B0) || (state == S_B1);
  end

  assign unused_bits = ^s_axis_tdata;

`ifdef ETH_RECV_SEQ_CHECK_EN
  logic [31:0] seq_reg;
  logic [31:0] seq_exp;
  logic [31:0] seq_beat;
  logic [31:0] seq_now;
  logic        first_frame;

  assign seq_beat = {s_axis_tdata[7:0], s_axis_tdata[15:8], s_axis_tdata[23:16], s_axis_tdata[31:24]};
  // A frame ending on the seq beat itself has not latched seq_reg yet
  assign seq_now  = (state == S_B2) ? seq_beat : seq_reg;
`else
  assign rx_seq_err_cnt = '0;
  assign rx_last_seq    = '0;
`endif

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= S_SYNC;
      etype          <= '0;
      len_acc        <= '0;
      rx_frame_cnt   <= '0;
      rx_byte_cnt    <= '0;
      rx_bad_cnt     <= '0;
      rx_runt_cnt    <= '0;
      rx_frame_pulse <= 1'b0;
`ifdef ETH_RECV_SEQ_CHECK_EN
      seq_reg        <= '0;
      seq_exp        <= '0;
      first_frame    <= 1'b1;
      rx_seq_err_cnt <= '0;
      rx_last_seq    <= '0;
`endif
    end else begin
      rx_frame_pulse <= 1'b0;
      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          state   <= S_B0;
          len_acc <= '0;
          if (state != S_SYNC) begin
            if (!s_axis_tuser) begin
              rx_bad_cnt <= sat_inc(rx_bad_cnt);
            end else begin
              rx_frame_cnt <= sat_inc(rx_frame_cnt);
              rx_byte_cnt  <= byte_sum[48] ? '1 : byte_sum[47:0];
              if (is_runt) begin
                rx_runt_cnt <= sat_inc(rx_runt_cnt);
              end else if (etype == ETHERTYPE) begin
                rx_frame_pulse <= 1'b1;
`ifdef ETH_RECV_SEQ_CHECK_EN
                if (!first_frame && (seq_now != seq_exp))
                  rx_seq_err_cnt <= sat_inc(rx_seq_err_cnt);
                first_frame <= 1'b0;
                seq_exp     <= seq_now + 32'd1;
                rx_last_seq <= seq_now;
`endif
              end
            end
          end
        end else begin
          if (state != S_SYNC) len_acc <= len_acc + 16'd8;
          case (state)
            S_SYNC: state <= S_SYNC;
            S_B0:   state <= S_B1;
            S_B1: begin
              state <= S_B2;
              etype <= {s_axis_tdata[39:32], s_axis_tdata[47:40]};
            end
            S_B2: begin
              state <= S_BODY;
`ifdef ETH_RECV_SEQ_CHECK_EN
              seq_reg <= seq_beat;
`endif
            end
            S_BODY:  state <= S_BODY;
            default: state <= S_SYNC;
          endcase
        end
      end
    end
  end

endmodule
